// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix rows/columns plus the decoded key output strobe.
// master = scanner side, slave = keypad matrix / key consumer side.
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  rows,
        output cols,
        output key,
        output key_valid,
        output key_held
    );

    modport slave (
        output rows,
        input  cols,
        input  key,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row sync, column scan, debounce FSM, one key_valid per press.
// Optional auto-repeat of a held key when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 64
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  kp
);

    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
        $error("keypad_scanner: illegal parameter values");
    end

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [3:0]    rows_meta, rows_sync;
    logic [SW-1:0] slot_cnt;
    logic [1:0]    col;
    logic          slot_end, scan_end;

    logic [3:0]    lows;
    logic [2:0]    col_n;
    logic [1:0]    col_row;
    logic [2:0]    tot;
    logic [1:0]    tot_sat;
    logic [1:0]    acc_n;
    logic [3:0]    acc_code, new_code;
    logic          res_none, res_single;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [3:0]    cand_q, cand_n;
    logic [3:0]    key_q, key_n;
    logic          valid_q, valid_n;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = 4'd10;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = 4'd11;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = 4'd12;
            4'b11_00: code = 4'd14;
            4'b11_01: code = 4'd0;
            4'b11_10: code = 4'd15;
            default:  code = 4'd13;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_meta <= '1;
            rows_sync <= '1;
        end else begin
            rows_meta <= kp.rows;
            rows_sync <= rows_meta;
        end
    end

    assign slot_end = (slot_cnt == SW'(SCAN_DIV - 1));
    assign scan_end = slot_end && (col == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            col      <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            col      <= col + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + SW'(1);
        end
    end

    assign kp.cols = ~(4'b0001 << col);

    // Contacts are tallied across the four column slots; the tally saturates at 2 (= MULTI).
    always_comb begin
        lows    = ~rows_sync;
        col_n   = {2'b00, lows[0]} + {2'b00, lows[1]} + {2'b00, lows[2]} + {2'b00, lows[3]};
        col_row = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (lows[i]) col_row = 2'(i);
        end
        tot      = {1'b0, acc_n} + col_n;
        tot_sat  = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        new_code = (col_n == 3'd1) ? key_code(col_row, col) : acc_code;
        res_none   = (tot == 3'd0);
        res_single = (tot == 3'd1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_n    <= '0;
            acc_code <= '0;
        end else if (slot_end) begin
            acc_n    <= (col == 2'd3) ? 2'd0 : tot_sat;
            acc_code <= new_code;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0] rep_q, rep_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rep_q <= '0;
        else       rep_q <= rep_n;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            cand_q  <= cand_n;
            key_q   <= key_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        cand_n  = cand_q;
        key_n   = key_q;
        valid_n = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_n   = rep_q;
`endif
        if (scan_end) begin
            case (state_q)
                IDLE: begin
                    if (res_single) begin
                        cand_n = new_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            key_n   = new_code;
                            valid_n = 1'b1;
                            state_n = PRESSED;
                            cnt_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_n   = '0;
`endif
                        end else begin
                            state_n = DEBOUNCE;
                            cnt_n   = CW'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (res_single && new_code == cand_q) begin
                        if (cnt_q == CW'(DEBOUNCE_SCANS - 1)) begin
                            key_n   = cand_q;
                            valid_n = 1'b1;
                            state_n = PRESSED;
                            cnt_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_n   = '0;
`endif
                        end else begin
                            cnt_n = cnt_q + CW'(1);
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                PRESSED: begin
                    if (res_none) begin
                        state_n = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
                        cnt_n   = (DEBOUNCE_SCANS == 1) ? CW'(0) : CW'(1);
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (res_single && new_code == key_q) begin
                        if (rep_q == RW'(REPEAT_SCANS - 1)) begin
                            valid_n = 1'b1;
                            rep_n   = '0;
                        end else begin
                            rep_n = rep_q + RW'(1);
                        end
                    end else begin
                        rep_n = '0;
                    end
`endif
                end
                RELEASE: begin
                    if (res_none) begin
                        if (cnt_q == CW'(DEBOUNCE_SCANS - 1)) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_q + CW'(1);
                        end
                    end else begin
                        state_n = PRESSED;
                        cnt_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_n   = '0;
`endif
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign kp.key       = key_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = (state_q == PRESSED) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=5 (scan = 16 clocks).
// A behavioural keypad drives rows from cols and the set of currently pressed keys.
module tb_keypad_scanner;

    localparam int unsigned SCAN = 16;
    localparam logic [3:0] KMAP [4][4] = '{
        '{4'd1,  4'd2, 4'd3,  4'd10},
        '{4'd4,  4'd5, 4'd6,  4'd11},
        '{4'd7,  4'd8, 4'd9,  4'd12},
        '{4'd14, 4'd0, 4'd15, 4'd13}
    };

    typedef struct {
        logic [15:0] mask;
        int unsigned scans;
        int unsigned exp_n;
        logic [3:0]  exp_key;
        logic        exp_held;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mask = '0;
    logic [3:0]  rows_m;
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned strobes = 0;
    int unsigned consec = 0;
    logic        prev_v = 1'b0;
    vec_t        vecs[$];

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_SCANS(3),
        .REPEAT_SCANS(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .kp(kp)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows_m = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kp.cols[c] && mask[KMAP[r][c]]) rows_m[r] = 1'b0;
            end
        end
    end
    assign kp.rows = rows_m;

    always @(negedge clk) begin
        if (kp.key_valid) begin
            strobes = strobes + 1;
            if (prev_v) consec = consec + 1;
        end
        prev_v = kp.key_valid;
    end

    function automatic logic [15:0] kbit(input int unsigned code);
        logic [15:0] m;
        m = '0;
        m[code] = 1'b1;
        return m;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input string nm, input logic [15:0] m, input int unsigned scans,
                         input int unsigned exp_n, input logic [3:0] exp_key, input logic exp_held);
        int unsigned s0;
        s0 = strobes;
        mask = m;
        repeat (scans * SCAN) @(negedge clk);
        check({nm, "/strobes"}, strobes - s0, exp_n);
        check({nm, "/key"}, {28'd0, kp.key}, {28'd0, exp_key});
        check({nm, "/held"}, {31'd0, kp.key_held}, {31'd0, exp_held});
    endtask

    initial begin
        // press/release pairs: '5', then 3,3,5,2,5,6
        vecs.push_back('{kbit(5), 5, 1, 4'd5, 1'b1});
        vecs.push_back('{16'd0,   5, 0, 4'd5, 1'b0});
        vecs.push_back('{kbit(3), 5, 1, 4'd3, 1'b1});
        vecs.push_back('{16'd0,   5, 0, 4'd3, 1'b0});
        vecs.push_back('{kbit(3), 5, 1, 4'd3, 1'b1});
        vecs.push_back('{16'd0,   5, 0, 4'd3, 1'b0});
        vecs.push_back('{kbit(5), 5, 1, 4'd5, 1'b1});
        vecs.push_back('{16'd0,   5, 0, 4'd5, 1'b0});
        vecs.push_back('{kbit(2), 5, 1, 4'd2, 1'b1});
        vecs.push_back('{16'd0,   5, 0, 4'd2, 1'b0});
        vecs.push_back('{kbit(5), 5, 1, 4'd5, 1'b1});
        vecs.push_back('{16'd0,   5, 0, 4'd5, 1'b0});
        vecs.push_back('{kbit(6), 5, 1, 4'd6, 1'b1});
        vecs.push_back('{16'd0,   5, 0, 4'd6, 1'b0});
        // two keys from idle, then rollover attempt and short release
        vecs.push_back('{kbit(5) | kbit(6), 6, 0, 4'd6, 1'b0});
        vecs.push_back('{16'd0,             5, 0, 4'd6, 1'b0});
        vecs.push_back('{kbit(5),           6, 1, 4'd5, 1'b1});
        vecs.push_back('{kbit(5) | kbit(6), 4, 0, 4'd5, 1'b1});
        vecs.push_back('{16'd0,             1, 0, 4'd5, 1'b1});
        vecs.push_back('{kbit(5),           3, 0, 4'd5, 1'b1});
        vecs.push_back('{16'd0,             5, 0, 4'd5, 1'b0});

        repeat (3) @(negedge clk);
        check("rst_cols",  {28'd0, kp.cols}, 32'hE);
        check("rst_key",   {28'd0, kp.key}, 32'd0);
        check("rst_valid", {31'd0, kp.key_valid}, 32'd0);
        check("rst_held",  {31'd0, kp.key_held}, 32'd0);

        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] expc;
            expc = ~(4'b0001 << (i / 4));
            check($sformatf("cols_cycle%0d", i), {28'd0, kp.cols}, {28'd0, expc});
            @(negedge clk);
        end

        for (int i = 0; i < 10; i++) begin
            apply($sformatf("bounce_on%0d", i),  kbit(3), 1, 0, 4'd0, 1'b0);
            apply($sformatf("bounce_off%0d", i), 16'd0,   1, 0, 4'd0, 1'b0);
        end

        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i].mask, vecs[i].scans,
                  vecs[i].exp_n, vecs[i].exp_key, vecs[i].exp_held);
        end

        // reset in the middle of debouncing '9'
        mask = kbit(9);
        repeat (24) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_cols",  {28'd0, kp.cols}, 32'hE);
        check("midrst_key",   {28'd0, kp.key}, 32'd0);
        check("midrst_valid", {31'd0, kp.key_valid}, 32'd0);
        check("midrst_held",  {31'd0, kp.key_held}, 32'd0);
        mask = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        apply("midrst_after", 16'd0, 5, 0, 4'd0, 1'b0);

`ifdef KEYPAD_AUTOREPEAT_EN
        apply("hold0", kbit(0), 21, 4, 4'd0, 1'b1);
`else
        apply("hold0", kbit(0), 21, 1, 4'd0, 1'b1);
`endif
        apply("hold0_rel", 16'd0, 5, 0, 4'd0, 1'b0);

        check("no_back_to_back", consec, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
